// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one WIDTH-bit up-counter between NREQ requesters.
// Round-robin arbitration picks a winner in IDLE; the winner's terminal count is
// latched at grant, the counter runs 0..limit (freezable by pause) and a one-cycle
// done pulse is returned to the winner. The just-served requester always becomes
// the lowest priority for the next round.
module counter_arbiter #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_limit,
   input  logic                  pause,
   output logic [NREQ-1:0]       gnt,
   output logic [IDW-1:0]        gnt_id,
   output logic                  busy,
   output logic [WIDTH-1:0]      count,
   output logic [NREQ-1:0]       done
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_e;

   state_e            state_q;
   logic [NREQ-1:0]   gnt_q;
   logic [NREQ-1:0]   done_q;
   logic [IDW-1:0]    gnt_id_q;
   logic [IDW-1:0]    last_q;
   logic              busy_q;
   logic [WIDTH-1:0]  count_q;
   logic [WIDTH-1:0]  lim_q;

   logic [IDW-1:0]    win_s;
   logic              win_vld_s;
   logic [NREQ-1:0]   win_onehot_s;
   logic [NREQ-1:0]   cur_onehot_s;
   logic [WIDTH-1:0]  win_limit_s;
   logic              req_cur_s;

   // Round-robin search: first set request starting just after the last winner.
   always_comb begin
      win_s     = '0;
      win_vld_s = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(last_q) + k) % NREQ;
         if (!win_vld_s && req[idx]) begin
            win_vld_s = 1'b1;
            win_s     = IDW'(idx);
         end else begin
            win_vld_s = win_vld_s;
         end
      end
   end

   // Decoded views of the candidate winner and of the requester currently served.
   always_comb begin
      win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
      cur_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id_q;
      win_limit_s  = req_limit[int'(win_s)*WIDTH +: WIDTH];
      req_cur_s    = req[gnt_id_q];
   end

   // Arbitration/count FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         count_q  <= '0;
         lim_q    <= '0;
         done_q   <= '0;
         last_q   <= IDW'(NREQ - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= '0;
               if (win_vld_s) begin
                  state_q  <= ST_COUNT;
                  gnt_q    <= win_onehot_s;
                  gnt_id_q <= win_s;
                  busy_q   <= 1'b1;
                  count_q  <= '0;
                  lim_q    <= win_limit_s;
                  last_q   <= win_s;
               end else begin
                  gnt_q  <= '0;
                  busy_q <= 1'b0;
               end
            end
            ST_COUNT: begin
               done_q <= '0;
               if (!req_cur_s) begin
                  // Requester withdrew: abandon the job silently, count holds.
                  state_q <= ST_IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (pause) begin
                  count_q <= count_q;
               end else if (count_q == lim_q) begin
                  // Terminal value reached: release and signal completion.
                  state_q <= ST_IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= cur_onehot_s;
               end else begin
                  count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_q <= ST_IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= '0;
            end
         endcase
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;
   assign count  = count_q;
   assign done   = done_q;

endmodule
